// File: rtl/uart_tx_fifo_ctrl.sv
// Byte FIFO feeding a UART transmitter one frame at a time; re-launches if i_Tx_Active never rises.
// Write-to-o_Tx_DV latency is 2 cycles; writes into a full FIFO are dropped and flagged in o_Overflow.
module uart_tx_fifo_ctrl #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACT_TIMEOUT = 3
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Wr_En,
  input  logic [7:0]        i_Wr_Byte,
  input  logic              i_Flush,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  input  logic              i_Clr_Ovf,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic [15:0]       o_Sent_Count
);

  localparam int TO_W = (ACT_TIMEOUT < 1) ? 1 : $clog2(ACT_TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_INIT = TO_W'(ACT_TIMEOUT);
  localparam logic [ADDR_W:0]   FULL_C  = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACT  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic [TO_W-1:0]   act_tmr;
  logic              pop;
  logic              push;
  logic              ovf_evt;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a write alongside it.
  assign pop     = (state == IDLE) && !o_Empty && !i_Tx_Active && !i_Flush;
  assign push    = i_Wr_En && (!o_Full || pop);
  assign ovf_evt = i_Wr_En && o_Full && !pop;

  always_comb begin
    count_nxt = o_Count;
    if (i_Flush)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = o_Count + (ADDR_W+1)'(1);
    else if (pop && !push)
      count_nxt = o_Count - (ADDR_W+1)'(1);
  end

  always_ff @(posedge i_Clock) begin
    if (push && !i_Flush)
      mem[wr_ptr] <= i_Wr_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Count    <= '0;
      o_Empty    <= 1'b1;
      o_Full     <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      if (i_Flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      o_Count <= count_nxt;
      o_Empty <= (count_nxt == '0);
      o_Full  <= (count_nxt == FULL_C);
      if (ovf_evt)
        o_Overflow <= 1'b1;
      else if (i_Clr_Ovf)
        o_Overflow <= 1'b0;
    end
  end

  // o_Tx_DV rises on the edge that leaves LAUNCH, so it is high for the first WAIT_ACT cycle.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= IDLE;
      o_Tx_DV      <= 1'b0;
      o_Tx_Byte    <= 8'h00;
      act_tmr      <= '0;
      o_Sent_Count <= 16'h0000;
    end else begin
      o_Tx_DV <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            o_Tx_Byte <= mem[rd_ptr];
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          o_Tx_DV <= 1'b1;
          act_tmr <= TO_INIT;
          state   <= WAIT_ACT;
        end
        WAIT_ACT: begin
          if (i_Tx_Active) begin
            state <= WAIT_DONE;
          end else begin
            if (act_tmr != '0)
              act_tmr <= act_tmr - TO_W'(1);
            if (act_tmr <= TO_W'(1))
              state <= LAUNCH;
          end
        end
        WAIT_DONE: begin
          if (i_Tx_Done) begin
            o_Sent_Count <= o_Sent_Count + 16'd1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo_ctrl;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_byte = 8'h00;
  logic              flush = 1'b0;
  logic              clr_ovf = 1'b0;
  logic              hold_busy = 1'b0;
  logic              tx_act = 1'b0;
  logic              tx_done = 1'b0;
  logic              tx_active;
  logic              o_full, o_empty, o_ovf, o_dv;
  logic [ADDR_W:0]   o_count;
  logic [7:0]        o_byte;
  logic [15:0]       o_sent;

  int npass = 0;
  int ntot  = 0;
  int frame_len = 4;
  int busy_cnt = 0;
  int ignore_req = 0;
  int ign_done = 0;
  int exp_sent = 0;
  logic [7:0] exp_q[$];
  logic       prev_dv = 1'b0;
  logic [7:0] exp_b;

  assign tx_active = tx_act | hold_busy;

  uart_tx_fifo_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ACT_TIMEOUT(3)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Wr_En(wr_en), .i_Wr_Byte(wr_byte),
    .i_Flush(flush), .o_Full(o_full), .o_Empty(o_empty), .o_Count(o_count),
    .o_Overflow(o_ovf), .i_Clr_Ovf(clr_ovf), .o_Tx_DV(o_dv), .o_Tx_Byte(o_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done), .o_Sent_Count(o_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write(input logic [7:0] b, input bit expect_tx);
    wr_en = 1'b1;
    wr_byte = b;
    if (expect_tx) exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_dv(input string name);
    for (int n = 0; n < 60; n++) begin
      tick();
      if (o_dv) break;
    end
    check(name, int'(o_dv), 1);
  endtask

  task automatic wait_sent(input int target);
    for (int n = 0; n < 2000; n++) begin
      if (int'(o_sent) == target) break;
      tick();
    end
    check("sent_count", int'(o_sent), target);
  endtask

  // Transmitter model: not reset with the DUT, acts just after each rising edge.
  always @(posedge clk) begin
    #1;
    tx_done = 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        tx_act  = 1'b0;
        tx_done = 1'b1;
      end
    end else if (o_dv) begin
      if (ign_done < ignore_req) ign_done++;
      else begin
        tx_act   = 1'b1;
        busy_cnt = frame_len;
      end
    end
  end

  // Scoreboard monitor: every launch pulse must match the next expected byte.
  always @(negedge clk) begin
    if (rst_n && o_dv) begin
      check("dv_not_consecutive", int'(prev_dv), 0);
      check("dv_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        check("tx_byte", int'(o_byte), int'(exp_b));
      end
    end
    prev_dv = o_dv;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int dvs;
    int n;

    // Reset state
    tick(); tick();
    check("rst_count", int'(o_count), 0);
    check("rst_empty", int'(o_empty), 1);
    check("rst_full", int'(o_full), 0);
    check("rst_ovf", int'(o_ovf), 0);
    check("rst_dv", int'(o_dv), 0);
    check("rst_byte", int'(o_byte), 0);
    check("rst_sent", int'(o_sent), 0);
    rst_n = 1'b1;
    tick(); tick();

    // Single byte latency
    write(8'hA5, 1);
    check("t1_count_after_write", int'(o_count), 1);
    check("t1_empty_after_write", int'(o_empty), 0);
    tick();
    check("t1_count_after_pop", int'(o_count), 0);
    check("t1_empty_after_pop", int'(o_empty), 1);
    check("t1_dv_not_yet", int'(o_dv), 0);
    tick();
    check("t1_dv_at_e2", int'(o_dv), 1);
    check("t1_byte", int'(o_byte), 8'hA5);
    tick();
    check("t1_dv_one_cycle", int'(o_dv), 0);
    exp_sent = 1;
    wait_sent(exp_sent);

    // Fill while transmitter busy, overflow, clear, drain in order
    hold_busy = 1'b1;
    for (int i = 1; i <= 16; i++) write(8'(i), 1);
    check("t2_full", int'(o_full), 1);
    check("t2_count16", int'(o_count), 16);
    check("t2_no_ovf_yet", int'(o_ovf), 0);
    write(8'h11, 0);
    check("t2_ovf_set", int'(o_ovf), 1);
    check("t2_count_still16", int'(o_count), 16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t2_ovf_cleared", int'(o_ovf), 0);
    hold_busy = 1'b0;
    exp_sent += 16;
    wait_sent(exp_sent);
    check("t2_empty_after_drain", int'(o_empty), 1);

    // Activity timeout: first launch ignored, same byte relaunched without a second pop
    ignore_req = ign_done + 1;
    write(8'h3C, 1);
    exp_q.push_back(8'h3C);
    write(8'h4D, 1);
    wait_dv("t3_first_dv");
    check("t3_count_first", int'(o_count), 1);
    wait_dv("t3_relaunch_dv");
    check("t3_relaunch_byte", int'(o_byte), 8'h3C);
    check("t3_count_relaunch", int'(o_count), 1);
    exp_sent += 2;
    wait_sent(exp_sent);

    // Full FIFO with simultaneous pop and write
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) write(8'(8'h20 + i), 1);
    check("t4_full", int'(o_full), 1);
    hold_busy = 1'b0;
    write(8'h55, 1);
    check("t4_count_push_pop", int'(o_count), 16);
    check("t4_full_kept", int'(o_full), 1);
    check("t4_no_ovf", int'(o_ovf), 0);
    exp_sent += 17;
    wait_sent(exp_sent);

    // Flush during an in-flight frame
    frame_len = 20;
    write(8'h60, 1);
    for (int i = 1; i <= 5; i++) write(8'(8'h60 + i), 0);
    check("t5_count5", int'(o_count), 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_count_flushed", int'(o_count), 0);
    check("t5_empty_flushed", int'(o_empty), 1);
    exp_sent += 1;
    wait_sent(exp_sent);
    dvs = 0;
    repeat (30) begin
      tick();
      if (o_dv) dvs++;
    end
    check("t5_no_dv_after_flush", dvs, 0);

    // Reset mid-frame: no launch until the transmitter goes idle, counter restarts
    write(8'h71, 1);
    wait_dv("t6_dv");
    repeat (3) tick();
    check("t6_busy_before_reset", int'(tx_active), 1);
    rst_n = 1'b0;
    tick();
    check("t6_sent_in_reset", int'(o_sent), 0);
    check("t6_dv_in_reset", int'(o_dv), 0);
    tick();
    rst_n = 1'b1;
    write(8'h72, 1);
    write(8'h73, 1);
    dvs = 0;
    n = 0;
    while (tx_active && n < 100) begin
      if (o_dv) dvs++;
      tick();
      n++;
    end
    check("t6_no_dv_while_busy", dvs, 0);
    check("t6_count_waiting", int'(o_count), 2);
    exp_sent = 2;
    wait_sent(exp_sent);

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
